// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: entry/SRCMD/MDCFG table layouts, access encodings and error record.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } access_t;

  localparam logic [2:0] ETYPE_NONE  = 3'd0;
  localparam logic [2:0] ETYPE_ILL_R = 3'd1;
  localparam logic [2:0] ETYPE_ILL_W = 3'd2;
  localparam logic [2:0] ETYPE_ILL_X = 3'd3;
  localparam logic [2:0] ETYPE_NOHIT = 3'd5;

  typedef struct packed {
    logic [31:0] q;
  } reg32_t;

  typedef struct packed {
    mode_t a;
    logic  x;
    logic  w;
    logic  r;
  } entry_cfg_t;

  // Entry address {addrh, addr} is the byte address shifted right by two.
  typedef struct packed {
    reg32_t     addrh;
    reg32_t     addr;
    entry_cfg_t cfg;
  } iopmp_entry_t;

  typedef struct packed {
    logic [30:0] md;
    logic        l;
  } srcmd_en_t;

  typedef struct packed {
    logic [31:0] mdh;
  } srcmd_enh_t;

  typedef struct packed {
    srcmd_enh_t enh;
    srcmd_en_t  en;
  } srcmd_entry_t;

  typedef struct packed {
    logic [15:0] q;
  } mdcfg_entry_t;

  typedef struct packed {
    logic        error_detected;
    logic [1:0]  ttype;
    logic [2:0]  etype;
    logic [15:0] err_reqid;
    logic [31:0] err_reqaddr;
    logic [31:0] err_reqaddrh;
  } error_capture_t;

  // One-hot access to 1 (R), 2 (W), 3 (X); anything else maps to 0.
  function automatic logic [1:0] access_code(input logic [2:0] acc);
    unique case (acc)
      ACCESS_READ:  access_code = 2'd1;
      ACCESS_WRITE: access_code = 2'd2;
      ACCESS_EXEC:  access_code = 2'd3;
      default:      access_code = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_iopmp_entry_match.sv
// Combinational address matcher for a single IOPMP entry (OFF/TOR/NA4/NAPOT).
module rv_iopmp_entry_match
  import rv_iopmp_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [63:0] entry_addr,
  input  logic [63:0] prev_addr,
  input  mode_t       mode,
  output logic        hit
);

  logic [63:0] napot_care;

  always_comb begin
    // A ^ (A+1) sets the trailing ones plus the next bit: exactly the ignored range.
    napot_care = ~(entry_addr ^ (entry_addr + 64'd1));
    hit        = 1'b0;
    unique case (mode)
      MODE_NA4:   hit = (addr == entry_addr);
      MODE_NAPOT: hit = ((addr ^ entry_addr) & napot_care) == 64'd0;
      MODE_TOR:   hit = (prev_addr <= addr) && (addr < entry_addr);
      default:    hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_iopmp_seq_checker.sv
// Multi-cycle IOPMP checker scanning ENTRIES_PER_CYCLE entries per cycle, first hit wins.
// Optional error capture register enabled by defining RV_IOPMP_ERR_CAPTURE_EN.
module rv_iopmp_seq_checker
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_ENTRY         = 16,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int NUM_MD            = 8,
  parameter int NUM_SID           = 4,
  parameter int ADDR_W            = 34,
  localparam int SID_W   = (NUM_SID > 1) ? $clog2(NUM_SID) : 1,
  localparam int ENTRY_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [SID_W-1:0]     req_sid_i,
  input  logic [2:0]           req_type_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_allow_o,
  output logic [2:0]           rsp_etype_o,
  output logic [ENTRY_W-1:0]   rsp_entry_o,
  input  iopmp_entry_t         entry_i [NUM_ENTRY],
  input  srcmd_entry_t         srcmd_i [NUM_SID],
  input  mdcfg_entry_t         mdcfg_i [NUM_MD],
  input  logic                 enable_i,
  output error_capture_t       err_o,
  input  logic                 err_clr_i
);

  localparam int NUM_WIN = NUM_ENTRY / ENTRIES_PER_CYCLE;
  localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [WIN_W-1:0]   LAST_WIN = WIN_W'(NUM_WIN - 1);
  localparam logic [ENTRY_W-1:0] ONE_IDX  = ENTRY_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-3:0]   waddr_reg, waddr_next;
  logic [SID_W-1:0]    sid_reg, sid_next;
  logic [2:0]          type_reg, type_next;
  logic [NUM_MD-1:0]   mask_reg, mask_next;
  logic [WIN_W-1:0]    win_reg, win_next;
  logic                allow_reg, allow_next;
  logic [2:0]          etype_reg, etype_next;
  logic [ENTRY_W-1:0]  entry_reg, entry_next;

  logic [63:0]         cmp_addr;
  logic [62:0]         sid_mask_full;
  logic [15:0]         md_lo [NUM_MD];
  logic [ENTRIES_PER_CYCLE-1:0] win_hit;
  logic [ENTRY_W-1:0]  win_idx [ENTRIES_PER_CYCLE];
  logic                any_hit;
  logic [ENTRY_W-1:0]  hit_idx;
  entry_cfg_t          hit_cfg;
  logic                hit_perm;

  assign cmp_addr      = 64'(waddr_reg);
  assign sid_mask_full = {srcmd_i[req_sid_i].enh.mdh, srcmd_i[req_sid_i].en.md};

  // Lower bound of each MD is the top of the previous MD.
  for (genvar gi = 0; gi < NUM_MD; gi++) begin : g_md_lo
    if (gi == 0) begin : g_first
      assign md_lo[gi] = 16'd0;
    end else begin : g_rest
      assign md_lo[gi] = mdcfg_i[gi-1].q;
    end
  end

  for (genvar gi = 0; gi < ENTRIES_PER_CYCLE; gi++) begin : g_win
    logic [ENTRY_W-1:0] idx;
    logic [63:0]        entry_addr;
    logic [63:0]        prev_addr;
    logic               applies;
    logic               match;

    assign idx        = ENTRY_W'(win_reg) * ENTRY_W'(ENTRIES_PER_CYCLE) + ENTRY_W'(gi);
    assign entry_addr = {entry_i[idx].addrh.q, entry_i[idx].addr.q};
    // TOR lower bound comes from the previous entry, even across a window edge.
    assign prev_addr  = (idx == '0) ? 64'd0
                        : {entry_i[idx - ONE_IDX].addrh.q, entry_i[idx - ONE_IDX].addr.q};

    always_comb begin
      applies = 1'b0;
      for (int m = 0; m < NUM_MD; m++) begin
        if (mask_reg[m] && (16'(idx) >= md_lo[m]) && (16'(idx) < mdcfg_i[m].q))
          applies = 1'b1;
      end
    end

    rv_iopmp_entry_match u_match (
      .addr       (cmp_addr),
      .entry_addr (entry_addr),
      .prev_addr  (prev_addr),
      .mode       (entry_i[idx].cfg.a),
      .hit        (match)
    );

    assign win_hit[gi] = applies & match;
    assign win_idx[gi] = idx;
  end

  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    hit_cfg = '0;
    for (int i = ENTRIES_PER_CYCLE - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        any_hit = 1'b1;
        hit_idx = win_idx[i];
        hit_cfg = entry_i[win_idx[i]].cfg;
      end
    end
    hit_perm = (type_reg[0] & hit_cfg.r) | (type_reg[1] & hit_cfg.w) | (type_reg[2] & hit_cfg.x);
  end

  always_comb begin
    state_next = state_reg;
    waddr_next = waddr_reg;
    sid_next   = sid_reg;
    type_next  = type_reg;
    mask_next  = mask_reg;
    win_next   = win_reg;
    allow_next = allow_reg;
    etype_next = etype_reg;
    entry_next = entry_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          waddr_next = req_addr_i[ADDR_W-1:2];
          sid_next   = req_sid_i;
          type_next  = req_type_i;
          mask_next  = sid_mask_full[NUM_MD-1:0];
          win_next   = '0;
          if (!enable_i) begin
            allow_next = 1'b1;
            etype_next = ETYPE_NONE;
            entry_next = '0;
            state_next = ST_RESP;
          end else if (!$onehot(req_type_i)) begin
            allow_next = 1'b0;
            etype_next = ETYPE_ILL_R;
            entry_next = '0;
            state_next = ST_RESP;
          end else begin
            state_next = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (any_hit) begin
          allow_next = hit_perm;
          etype_next = hit_perm ? ETYPE_NONE : {1'b0, access_code(type_reg)};
          entry_next = hit_idx;
          state_next = ST_RESP;
        end else if (win_reg == LAST_WIN) begin
          allow_next = 1'b0;
          etype_next = ETYPE_NOHIT;
          entry_next = '0;
          state_next = ST_RESP;
        end else begin
          win_next = win_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      waddr_reg <= '0;
      sid_reg   <= '0;
      type_reg  <= '0;
      mask_reg  <= '0;
      win_reg   <= '0;
      allow_reg <= 1'b0;
      etype_reg <= '0;
      entry_reg <= '0;
    end else begin
      state_reg <= state_next;
      waddr_reg <= waddr_next;
      sid_reg   <= sid_next;
      type_reg  <= type_next;
      mask_reg  <= mask_next;
      win_reg   <= win_next;
      allow_reg <= allow_next;
      etype_reg <= etype_next;
      entry_reg <= entry_next;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign rsp_valid_o = (state_reg == ST_RESP);
  assign rsp_allow_o = allow_reg;
  assign rsp_etype_o = etype_reg;
  assign rsp_entry_o = entry_reg;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

`ifdef RV_IOPMP_ERR_CAPTURE_EN
  error_capture_t err_reg, err_next;
  logic [63:0]    err_waddr;

  assign err_waddr = 64'(waddr_next);

  // Capture on entry into RESP so a long-stalled response is recorded only once.
  always_comb begin
    err_next = err_reg;
    if (err_clr_i) begin
      err_next = '0;
    end else if ((state_next == ST_RESP) && (state_reg != ST_RESP) && !allow_next
                 && !err_reg.error_detected) begin
      err_next.error_detected = 1'b1;
      err_next.ttype          = access_code(type_next);
      err_next.etype          = etype_next;
      err_next.err_reqid      = 16'(sid_next);
      err_next.err_reqaddr    = err_waddr[31:0];
      err_next.err_reqaddrh   = err_waddr[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_reg <= '0;
    else       err_reg <= err_next;
  end

  assign err_o = err_reg;
`else
  logic unused_err;
  assign unused_err = err_clr_i ^ (^sid_reg);
  assign err_o      = '0;
`endif

endmodule
